// File: rtl/conv_feeder_pkg.sv
// Shared types and constants for the convolution-engine input feeder.
package conv_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILTER,
    GAP,
    IMAGE,
    WAIT_OUT,
    DONE
  } feeder_state_e;

  // Which stream a memory read belongs to, carried alongside rd_en.
  typedef enum logic [1:0] {
    PH_NONE,
    PH_FILT,
    PH_IMG
  } beat_phase_e;

  localparam int FILT3_BEATS = 9;
  localparam int FILT5_BEATS = 25;
  localparam int MIN_IMG     = 3;

  typedef struct packed {
    logic       filter_size;
    logic [3:0] image_size;
    logic       pad_mode;
    logic       act_mode;
  } feeder_cfg_t;

endpackage

// File: rtl/conv_feeder_rdpipe.sv
// Read-to-beat stage: the valid strobes are delayed one cycle to line up with
// the memory's rd_data, and in_data is that data gated by the delayed strobe.
module conv_feeder_rdpipe
  import conv_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en_i,
  input  beat_phase_e phase_i,
  input  logic [7:0]  rd_data_i,
  output logic        filter_valid_o,
  output logic        image_valid_o,
  output logic [7:0]  in_data_o
);

  logic fv_q, iv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q <= 1'b0;
      iv_q <= 1'b0;
    end else begin
      fv_q <= rd_en_i && (phase_i == PH_FILT);
      iv_q <= rd_en_i && (phase_i == PH_IMG);
    end
  end

  // rd_data already arrives one cycle after rd_en, so it is the registered beat.
  assign filter_valid_o = fv_q;
  assign image_valid_o  = iv_q;
  assign in_data_o      = (fv_q || iv_q) ? rd_data_i : 8'h00;

endmodule

// File: rtl/conv_feeder.sv
// Streams filter then image bytes from local memory into the conv engine and
// counts returned results. Optional watchdog: define CONV_FEEDER_TIMEOUT_EN.
module conv_feeder
  import conv_feeder_pkg::*;
#(
  parameter int MAX_IMG        = 8,
  parameter int GAP_CYCLES     = 1,
  parameter int ADDR_W         = 7,
  parameter int IMG_BASE       = 25,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_filter_size,
  input  logic [3:0]        cfg_image_size,
  input  logic              cfg_pad_mode,
  input  logic              cfg_act_mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              filter_valid,
  output logic              image_valid,
  output logic              filter_size,
  output logic              pad_mode,
  output logic              act_mode,
  output logic [3:0]        image_size,
  output logic [7:0]        in_data,
  input  logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef CONV_FEEDER_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int CNT_W = $clog2(MAX_IMG * MAX_IMG + 1);

  feeder_state_e     state_q, state_d;
  feeder_cfg_t       cfg_q, cfg_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]  filt_total, img_total;
  logic              start_ok, size_bad, counting, res_hit;
  beat_phase_e       phase;

`ifdef CONV_FEEDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;
`endif

  assign filt_total = cfg_q.filter_size ? CNT_W'(FILT5_BEATS) : CNT_W'(FILT3_BEATS);
  assign img_total  = CNT_W'(cfg_q.image_size) * CNT_W'(cfg_q.image_size);

  // The done cycle is already IDLE; holding off start there keeps done a clean edge.
  assign start_ok = start && (state_q == IDLE) && !done_q;
  assign size_bad = (cfg_image_size < 4'(MIN_IMG)) || (cfg_image_size > 4'(MAX_IMG));
  assign counting = state_q inside {FILTER, GAP, IMAGE, WAIT_OUT};

  always_comb begin
    res_cnt_d = res_cnt_q;
    if (counting && out_valid && (res_cnt_q != img_total))
      res_cnt_d = res_cnt_q + 1'b1;
    if (start_ok)
      res_cnt_d = '0;
  end

  assign res_hit = (res_cnt_d == img_total);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_err_d  = cfg_err_q;
`ifdef CONV_FEEDER_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    to_err_d   = to_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          cfg_d.filter_size = cfg_filter_size;
          cfg_d.image_size  = cfg_image_size;
          cfg_d.pad_mode    = cfg_pad_mode;
          cfg_d.act_mode    = cfg_act_mode;
          beat_cnt_d        = '0;
          busy_d            = 1'b1;
          cfg_err_d         = size_bad;
          state_d           = size_bad ? DONE : FILTER;
`ifdef CONV_FEEDER_TIMEOUT_EN
          to_cnt_d          = '0;
          to_err_d          = 1'b0;
`endif
        end
      end
      FILTER: begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        if (beat_cnt_q == filt_total - 1'b1) begin
          beat_cnt_d = '0;
          state_d    = (GAP_CYCLES > 0) ? GAP : IMAGE;
        end
      end
      GAP: begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        if (beat_cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          beat_cnt_d = '0;
          state_d    = IMAGE;
        end
      end
      IMAGE: begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        if (beat_cnt_q == img_total - 1'b1) begin
          beat_cnt_d = '0;
          state_d    = res_hit ? DONE : WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (res_hit) begin
          state_d = DONE;
        end
`ifdef CONV_FEEDER_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = DONE;
          to_err_d = 1'b1;
        end
        to_cnt_d = to_cnt_q + 1'b1;
`endif
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      beat_cnt_q <= '0;
      res_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      beat_cnt_q <= beat_cnt_d;
      res_cnt_q  <= res_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef CONV_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`endif

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    phase   = PH_NONE;
    if (state_q == FILTER) begin
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(beat_cnt_q);
      phase   = PH_FILT;
    end else if (state_q == IMAGE) begin
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(IMG_BASE) + ADDR_W'(beat_cnt_q);
      phase   = PH_IMG;
    end
  end

  conv_feeder_rdpipe u_rdpipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_en_i        (rd_en),
    .phase_i        (phase),
    .rd_data_i      (rd_data),
    .filter_valid_o (filter_valid),
    .image_valid_o  (image_valid),
    .in_data_o      (in_data)
  );

  assign filter_size = busy_q & cfg_q.filter_size;
  assign image_size  = busy_q ? cfg_q.image_size : 4'h0;
  assign pad_mode    = busy_q & cfg_q.pad_mode;
  assign act_mode    = busy_q & cfg_q.act_mode;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_conv_feeder.sv
// Randomized bench for conv_feeder; the per-cycle expectation is derived from
// the job timeline (beat windows, result count, done cycle) in plain arithmetic.
module tb_conv_feeder;

  localparam int GAP      = 1;
  localparam int IMG_BASE = 25;
  localparam int MAX_IMG  = 8;
`ifdef CONV_FEEDER_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1024;
`endif

  logic       clk, rst_n, start;
  logic       cfg_filter_size, cfg_pad_mode, cfg_act_mode;
  logic [3:0] cfg_image_size;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       filter_valid, image_valid;
  logic       filter_size, pad_mode, act_mode;
  logic [3:0] image_size;
  logic [7:0] in_data;
  logic       out_valid, busy, done, cfg_err;
`ifdef CONV_FEEDER_TIMEOUT_EN
  logic       timeout_err;
`endif

  logic [7:0] mem [0:127];
  int n_chk = 0;
  int n_err = 0;

  conv_feeder #(
    .MAX_IMG(MAX_IMG), .GAP_CYCLES(GAP), .ADDR_W(7), .IMG_BASE(IMG_BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_filter_size(cfg_filter_size), .cfg_image_size(cfg_image_size),
    .cfg_pad_mode(cfg_pad_mode), .cfg_act_mode(cfg_act_mode),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .filter_valid(filter_valid), .image_valid(image_valid),
    .filter_size(filter_size), .pad_mode(pad_mode), .act_mode(act_mode),
    .image_size(image_size), .in_data(in_data), .out_valid(out_valid),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef CONV_FEEDER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one cycle of read latency; garbage when not reading.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      out_valid = 1'($urandom);
      @(negedge clk);
      chk("idle busy", 32'(busy), 0);
      chk("idle done", 32'(done), 0);
      chk("idle strobes", 32'({filter_valid, image_valid}), 0);
      chk("idle in_data", 32'(in_data), 0);
    end
    out_valid = 1'b0;
  endtask

  // s2: extra start at that job cycle (-1 none, -2 in the done cycle).
  task automatic run_job(input bit fs, input int n, input bit pad, input bit act,
                         input int mode, input int s2);
    bit         ov [512];
    int         kk, nn, L, D, c, cum, t, np;
    bit         legal, exp_to, fv, iv, bz;
    logic [6:0] cfgv;
    logic [7:0] d;
    kk    = fs ? 25 : 9;
    legal = (n >= 3) && (n <= MAX_IMG);
    nn    = n * n;
    foreach (ov[i]) ov[i] = 1'b0;
    case (mode)
      0: begin
        t  = $urandom_range(1, 6);
        np = nn + int'($urandom_range(0, 3));
        for (int p = 0; p < np; p++) begin
          if (t < 512) ov[t] = 1'b1;
          t += $urandom_range(1, 3);
        end
      end
      1: for (int p = 1; p <= nn; p++) ov[p] = 1'b1;
      default: for (int p = 1; p <= 5; p++) ov[p] = 1'b1;
    endcase
    L = kk + GAP + nn;
    exp_to = 1'b0;
    if (!legal) D = 2;
    else begin
      cum = 0; c = 100000;
      for (int i = 1; i < 512; i++) begin
        cum += int'(ov[i]);
        if (cum == nn) begin c = i; break; end
      end
      D = (c <= L) ? L + 2 : c + 2;
`ifdef CONV_FEEDER_TIMEOUT_EN
      if (c > L + TO) begin D = L + TO + 2; exp_to = 1'b1; end
`endif
    end
    cfgv = {fs, 4'(n), pad, act};
    for (int i = 0; i <= D + 1; i++) begin
      @(posedge clk); #1;
      start = (i == 0) || (i == s2) || (s2 == -2 && i == D);
      if (i == 0) {cfg_filter_size, cfg_image_size, cfg_pad_mode, cfg_act_mode} = cfgv;
      else        {cfg_filter_size, cfg_image_size, cfg_pad_mode, cfg_act_mode} = 7'($urandom);
      out_valid = (i < 512) ? ov[i] : 1'b0;
      @(negedge clk);
      fv = legal && i >= 2 && i <= 1 + kk;
      iv = legal && i >= 2 + kk + GAP && i <= 1 + kk + GAP + nn;
      bz = i >= 1 && i < D;
      d  = fv ? mem[i - 2] : iv ? mem[IMG_BASE + i - 2 - kk - GAP] : 8'h00;
      chk($sformatf("n%0d c%0d filter_valid", n, i), 32'(filter_valid), 32'(fv));
      chk($sformatf("n%0d c%0d image_valid", n, i), 32'(image_valid), 32'(iv));
      chk($sformatf("n%0d c%0d in_data", n, i), 32'(in_data), 32'(d));
      chk($sformatf("n%0d c%0d busy", n, i), 32'(busy), 32'(bz));
      chk($sformatf("n%0d c%0d done", n, i), 32'(done), 32'(i == D));
      chk($sformatf("n%0d c%0d sideband", n, i),
          32'({filter_size, image_size, pad_mode, act_mode}), bz ? 32'(cfgv) : 0);
      if (i >= 1) chk($sformatf("n%0d c%0d cfg_err", n, i), 32'(cfg_err), 32'(!legal));
`ifdef CONV_FEEDER_TIMEOUT_EN
      if (i == 1) chk("timeout_err cleared", 32'(timeout_err), 0);
      if (i == D) chk("timeout_err at done", 32'(timeout_err), 32'(exp_to));
`endif
    end
    start     = 1'b0;
    out_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_valid = 1'b0; rd_data = 8'h00;
    {cfg_filter_size, cfg_image_size, cfg_pad_mode, cfg_act_mode} = '0;
    for (int a = 0; a < 128; a++) mem[a] = 8'(a);
    #1;
    chk("reset rd_en", 32'(rd_en), 0);
    chk("reset rd_addr", 32'(rd_addr), 0);
    chk("reset strobes", 32'({filter_valid, image_valid, busy, done, cfg_err}), 0);
    chk("reset in_data", 32'(in_data), 0);
    chk("reset sideband", 32'({filter_size, image_size, pad_mode, act_mode}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_job(1'b0, 4, 1'b0, 1'b0, 0, -1);
    run_job(1'b1, 8, 1'b1, 1'b1, 0, -1);
    run_job(1'b0, 2, 1'b1, 1'b0, 0, -1);
    run_job(1'b1, 9, 1'b0, 1'b1, 0, -1);
    run_job(1'b1, 5, 1'b0, 1'b1, 1, -1);
    idle_cycles(6);
    run_job(1'b0, 3, 1'b1, 1'b1, 1, 9 + GAP + 4);
    run_job(1'b0, 4, 1'b0, 1'b1, 0, -2);

    // Abort mid-filter: strobes must fall with rst_n, not on a clock edge.
    @(posedge clk); #1;
    start = 1'b1; {cfg_filter_size, cfg_image_size, cfg_pad_mode, cfg_act_mode} = {1'b0, 4'd5, 2'b00};
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre-reset filter_valid", 32'(filter_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset filter_valid", 32'(filter_valid), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset rd_en", 32'(rd_en), 0);
    chk("async reset in_data", 32'(in_data), 0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(10);

    for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    run_job(1'b1, 6, 1'b1, 1'b0, 0, -1);
    for (int j = 0; j < 10; j++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(3, 8));
      run_job(1'($urandom), n, 1'($urandom), 1'($urandom), int'($urandom_range(0, 1)), -1);
      if (j % 3 == 0) idle_cycles(3);
    end
`ifdef CONV_FEEDER_TIMEOUT_EN
    run_job(1'b0, 3, 1'b0, 1'b0, 2, -1);
    run_job(1'b0, 3, 1'b0, 1'b0, 1, -1);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
